// File: rtl/if_id_decode_stage.sv
// IF/ID pipeline register with MIPS main decode, registered as a unit.
// Optional IF_ID_PERF_EN adds stall_cnt/flush_cnt performance counters.
module if_id_decode_stage #(
  parameter int unsigned           WORD_W   = 32,
  parameter logic [WORD_W-1:0]     NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] instr_in,
  input  logic [WORD_W-1:0] pc4_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc4,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [WORD_W-1:0] imm_ext,
  output logic [WORD_W-1:0] br_target,
  output logic [WORD_W-1:0] j_target,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              jump,
  output logic [2:0]        alu_op,
  output logic              illegal
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam int unsigned IMM_W = 16;
  localparam int unsigned EXT_W = WORD_W - IMM_W;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

  ctrl_t             ctrl_d;
  ctrl_t             ctrl_q;
  logic              zero_ext_c;
  logic [WORD_W-1:0] imm_d;
  logic [WORD_W-1:0] br_d;
  logic [WORD_W-1:0] j_d;
  logic              load_c;
  logic              drain_c;

  assign in_ready = !out_valid || out_ready;
  assign load_c   = in_valid && in_ready;
  assign drain_c  = out_valid && out_ready && !load_c;

  // Main decoder on the incoming word; result is captured together with it
  always_comb begin
    ctrl_d     = '0;
    zero_ext_c = 1'b0;
    case (instr_in[31:26])
      OP_RTYPE: begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = 3'b010;
      end
      OP_LW: begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_read   = 1'b1;
      end
      OP_SW: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = 3'b001;
      end
      OP_ADDI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      OP_SLTI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = 3'b101;
      end
      OP_ANDI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = 3'b011;
        zero_ext_c       = 1'b1;
      end
      OP_ORI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = 3'b100;
        zero_ext_c       = 1'b1;
      end
      OP_J: begin
        ctrl_d.jump = 1'b1;
      end
      default: begin
        ctrl_d.illegal = 1'b1;
      end
    endcase
  end

  // Branch offset always uses the sign-extended immediate; the add wraps
  assign imm_d = zero_ext_c ? {EXT_W'(0), instr_in[15:0]}
                            : {{EXT_W{instr_in[15]}}, instr_in[15:0]};
  assign br_d  = pc4_in + {{(EXT_W-2){instr_in[15]}}, instr_in[15:0], 2'b00};
  assign j_d   = {pc4_in[31:28], instr_in[25:0], 2'b00};

  // Stage register: flush beats load, load beats drain, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      instr     <= NOP_WORD;
      pc4       <= '0;
      imm_ext   <= '0;
      br_target <= '0;
      j_target  <= '0;
      ctrl_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      instr     <= NOP_WORD;
      pc4       <= '0;
      imm_ext   <= '0;
      br_target <= '0;
      j_target  <= '0;
      ctrl_q    <= '0;
    end else if (load_c) begin
      out_valid <= 1'b1;
      instr     <= instr_in;
      pc4       <= pc4_in;
      imm_ext   <= imm_d;
      br_target <= br_d;
      j_target  <= j_d;
      ctrl_q    <= ctrl_d;
    end else if (drain_c) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
    end
  end

  assign opcode     = instr[31:26];
  assign rs         = instr[25:21];
  assign rt         = instr[20:16];
  assign rd         = instr[15:11];
  assign shamt      = instr[10:6];
  assign funct      = instr[5:0];
  assign reg_dst    = ctrl_q.reg_dst;
  assign alu_src    = ctrl_q.alu_src;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign branch     = ctrl_q.branch;
  assign jump       = ctrl_q.jump;
  assign alu_op     = ctrl_q.alu_op;
  assign illegal    = ctrl_q.illegal;

`ifdef IF_ID_PERF_EN
  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
      if (flush)                   flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/if_id_decode_stage.md
Name: if_id_decode_stage

Overview:
- IF/ID pipeline boundary plus instruction decode for the 32-bit MIPS core.
- Sits directly downstream of the fetch cycle. Captures the fetched instruction word and its PC+4, then registers the decoded fields, sign/zero-extended immediate, branch and jump targets, and main control signals for the execute stage.
- Valid/ready handshakes on both sides, plus a flush for taken branches and jumps.

Parameters:
- WORD_W, 32, instruction and PC width; only 32 is supported.
- NOP_WORD, 32'h0000_0000, instruction word loaded on flush and reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents instr_in and pc4_in
- in_ready  out  1  stage can accept this cycle
- instr_in  in  32  fetched instruction word
- pc4_in  in  32  PC+4 of the fetched instruction
- flush  in  1  squash the held and incoming instruction
- out_valid  out  1  decoded outputs are valid
- out_ready  in  1  execute stage accepts
- instr  out  32  held instruction word
- pc4  out  32  held PC+4
- opcode  out  6  instr[31:26]
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
- shamt  out  5  instr[10:6]
- funct  out  6  instr[5:0]
- imm_ext  out  32  extended immediate
- br_target  out  32  pc4 + (sign-extended imm << 2)
- j_target  out  32  {pc4[31:28], instr[25:0], 2'b00}
- reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump  out  1 each  control signals
- alu_op  out  3  ALU operation class
- illegal  out  1  unsupported opcode

Behaviour:
- Reset (async, rst_n=0): out_valid=0, instr=NOP_WORD, pc4=0. All derived fields and controls are 0.
- Handshake: in_ready = !out_valid || out_ready (combinational). A load occurs when in_valid && in_ready.
- Latency: one cycle. All outputs are registered from the stored word/pc4 and change only on load, flush, or reset.
- Load: instr<=instr_in, pc4<=pc4_in, out_valid<=1.
- Drain without load (out_valid && out_ready && !(in_valid && in_ready)): out_valid<=0; held data is retained.
- Stall (out_valid && !out_ready): all registers hold and in_ready=0.
- Flush has priority over load and stall: next cycle out_valid=0, instr=NOP_WORD, controls=0. The incoming word is dropped even if in_valid=1.
- Decode is a combinational function of the held instr, registered as a whole with it. Controls are forced to 0 whenever out_valid=0.
- R-type 000000: reg_dst, reg_write; alu_op=010.
- lw 100011: alu_src, mem_to_reg, reg_write, mem_read; alu_op=000.
- sw 101011: alu_src, mem_write; alu_op=000.
- beq 000100: branch; alu_op=001.
- addi 001000: alu_src, reg_write; alu_op=000; sign-extend.
- slti 001010: alu_src, reg_write; alu_op=101; sign-extend.
- andi 001100: alu_src, reg_write; alu_op=011; zero-extend.
- ori 001101: alu_src, reg_write; alu_op=100; zero-extend.
- j 000010: jump; alu_op=000.
- Any other opcode: all controls 0, illegal=1, out_valid still 1.
- Arithmetic: br_target is a 32-bit add modulo 2^32 (wraps with no flag). Shifts discard the upper bits.
- NOP word 0x00000000 decodes as R-type sll and is harmless: reg_write=1 to rd=0.
- Reset mid-stall: outputs clear immediately; in_ready=1 once rst_n deasserts.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- When defined: adds outputs stall_cnt[31:0] (cycles with out_valid && !out_ready) and flush_cnt[15:0] (cycles with flush=1).
  - Both counters reset to 0 and wrap on overflow.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset released, in_valid=0 -> out_valid=0, in_ready=1, instr=0, all controls 0.
- Load 0x00221820 (add $3,$1,$2), pc4_in=0x4, out_ready=1 -> next cycle rs=1, rt=2, rd=3, funct=0x20, reg_dst=1, reg_write=1, alu_op=010.
- Load 0x8D280004 (lw $8,4($9)) -> rs=9, rt=8, imm_ext=0x4, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1.
- Load 0x1022FFFF with pc4_in=0x10 -> branch=1, imm_ext=0xFFFFFFFF, br_target=0x0000000C. Load 0x08000010 with pc4_in=0x8 -> jump=1, j_target=0x00000040.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs frozen. Then flush=1 -> out_valid=0, instr=0. Incoming word accepted the cycle after.
- Load 0xFC000000 -> illegal=1, all controls 0. Assert rst_n=0 mid-stall -> outputs clear asynchronously.
